// File: rtl/dmem_responder.sv
// Word-addressed data memory slave with a fixed number of wait states per access.
// Holds the pipeline on stall while an access is outstanding and flags illegal requests.
module dmem_responder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              stall,
    output logic              addr_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              addr_err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_addr;
    logic              req;
    logic              illegal;
    logic              accept;
    logic              reject;
    logic              commit;

    // Upper address bits only matter for the range check, done on the full word address.
    assign word_addr = addr >> 2;
    assign req       = mem_read | mem_write;
    assign illegal   = (mem_read & mem_write) | (addr[1:0] != 2'b00) |
                       (word_addr >= ADDR_W'(DEPTH));
    assign accept    = (state_q == StIdle) & req & ~illegal;
    assign reject    = (state_q == StIdle) & req & illegal;
    assign commit    = (state_q == StBusy) & (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StBusy;
                    cnt_d   = 4'(LATENCY - 1);
                    stall   = 1'b1;
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                // Inputs still belong to the instruction just served.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= commit & ~write_q;
            addr_err_q <= reject;
            if (commit && !write_q) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= addr[IDX_W+1:2];
            wdata_q <= wdata;
            write_q <= mem_write;
        end
    end

    // Array is not reset; a reset in the commit cycle must still suppress the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && write_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset corner cases,
// and randomized accesses against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              stall;
    logic              addr_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        bit          hold;
        bit          err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    dmem_responder #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .stall    (stall),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic bit is_illegal(input bit rd, input bit wr, input logic [31:0] a);
        return (rd && wr) || (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            #1;
            chk("idle stall", 32'(stall), 32'd0);
            chk("idle rvalid", 32'(rvalid), 32'd0);
            chk("idle addr_err", 32'(addr_err), 32'd0);
            chk("idle rdata hold", rdata, model_rdata);
        end
    endtask

    // Presents one request in cycle T and checks every cycle until the access is finished.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, input bit exp_err,
                          input logic [31:0] exp_rd, input string nm);
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        #1;
        chk({nm, " stall@T"}, 32'(stall), exp_err ? 32'd0 : 32'd1);
        chk({nm, " rvalid@T"}, 32'(rvalid), 32'd0);
        if (exp_err) begin
            @(negedge clk);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            #1;
            chk({nm, " addr_err pulse"}, 32'(addr_err), 32'd1);
            chk({nm, " err stall"}, 32'(stall), 32'd0);
            chk({nm, " err rvalid"}, 32'(rvalid), 32'd0);
            chk({nm, " err rdata kept"}, rdata, model_rdata);
            @(negedge clk);
            #1;
            chk({nm, " addr_err clear"}, 32'(addr_err), 32'd0);
            chk({nm, " post-err stall"}, 32'(stall), 32'd0);
        end else begin
            for (int k = 1; k <= int'(LATENCY); k++) begin
                @(negedge clk);
                if (!hold) begin
                    addr  = a ^ 32'h4;
                    wdata = ~wd;
                end
                #1;
                chk({nm, " busy stall"}, 32'(stall), 32'd1);
                chk({nm, " busy rvalid"}, 32'(rvalid), 32'd0);
            end
            @(negedge clk);
            if (!hold) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            #1;
            if (rd) model_rdata = exp_rd;
            if (wr) model_mem[a[9:2]] = wd;
            chk({nm, " done stall"}, 32'(stall), 32'd0);
            chk({nm, " done rvalid"}, 32'(rvalid), 32'(rd));
            chk({nm, " done addr_err"}, 32'(addr_err), 32'd0);
            chk({nm, " done rdata"}, rdata, model_rdata);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        model_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset rvalid", 32'(rvalid), 32'd0);
        chk("reset addr_err", 32'(addr_err), 32'd0);
        chk("reset rdata", rdata, 32'h0);

        for (int i = 0; i < int'(DEPTH); i++) begin
            access(1'b0, 1'b1, 32'(i) << 2, init_val(i), 1'b0, 1'b0, 32'h0, "init");
        end

        vecs[0]  = '{rd: 0, wr: 1, a: 32'h10,  wd: 32'hDEADBEEF, hold: 0, err: 0, exp_rd: 0};
        vecs[1]  = '{rd: 1, wr: 0, a: 32'h10,  wd: 32'h0, hold: 0, err: 0, exp_rd: 32'hDEADBEEF};
        vecs[2]  = '{rd: 1, wr: 0, a: 32'h13,  wd: 32'h0, hold: 0, err: 1, exp_rd: 0};
        vecs[3]  = '{rd: 0, wr: 1, a: 32'h20,  wd: 32'hAAAA5555, hold: 0, err: 0, exp_rd: 0};
        vecs[4]  = '{rd: 1, wr: 1, a: 32'h20,  wd: 32'h1, hold: 0, err: 1, exp_rd: 0};
        vecs[5]  = '{rd: 1, wr: 0, a: 32'h20,  wd: 32'h0, hold: 0, err: 0, exp_rd: 32'hAAAA5555};
        vecs[6]  = '{rd: 0, wr: 1, a: 32'h400, wd: 32'h55, hold: 0, err: 1, exp_rd: 0};
        vecs[7]  = '{rd: 1, wr: 0, a: 32'h400, wd: 32'h0, hold: 0, err: 1, exp_rd: 0};
        vecs[8]  = '{rd: 0, wr: 1, a: 32'h3FC, wd: 32'h0BADF00D, hold: 0, err: 0, exp_rd: 0};
        vecs[9]  = '{rd: 1, wr: 0, a: 32'h3FC, wd: 32'h0, hold: 1, err: 0, exp_rd: 32'h0BADF00D};
        vecs[10] = '{rd: 1, wr: 0, a: 32'h14,  wd: 32'h0, hold: 0, err: 0, exp_rd: 32'hC0DE0005};
        vecs[11] = '{rd: 1, wr: 0, a: 32'h8000_0010, wd: 32'h0, hold: 0, err: 1, exp_rd: 0};

        idle(1);
        for (int i = 0; i < 12; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].hold,
                   vecs[i].err, vecs[i].exp_rd, $sformatf("vec%0d", i));
            if (i == 9) idle(1);
        end

        // Read 0x10 with addr toggled during BUSY; then a held request must not be re-served.
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, "toggle rd");
        access(1'b0, 1'b1, 32'h18, 32'h600D_CAFE, 1'b1, 1'b0, 32'h0, "held wr");
        idle(1);
        // Back-to-back: next request accepted right after DONE, rdata held across the write.
        access(1'b0, 1'b1, 32'h1C, 32'h1111_2222, 1'b0, 1'b0, 32'h0, "b2b wr");
        access(1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 32'h600D_CAFE, "b2b rd");

        // Reset in the first BUSY cycle and in the commit cycle: no write may land.
        for (int r = 1; r <= int'(LATENCY); r++) begin
            @(negedge clk);
            mem_write = 1'b1;
            addr      = 32'h20;
            wdata     = 32'h12345678;
            #1;
            chk("rst-mid stall@T", 32'(stall), 32'd1);
            for (int k = 1; k < r; k++) begin
                @(negedge clk);
                mem_write = 1'b0;
                #1;
                chk("rst-mid busy stall", 32'(stall), 32'd1);
            end
            @(negedge clk);
            mem_write = 1'b0;
            rst       = 1'b1;
            #1;
            chk("rst-mid busy stall", 32'(stall), 32'd1);
            @(negedge clk);
            rst = 1'b0;
            #1;
            model_rdata = 32'h0;
            chk("rst-mid stall", 32'(stall), 32'd0);
            chk("rst-mid rvalid", 32'(rvalid), 32'd0);
            chk("rst-mid rdata", rdata, 32'h0);
            access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'hAAAA5555, "rst-mid readback");
        end

        for (int n = 0; n < 300; n++) begin
            bit          rd;
            bit          wr;
            logic [31:0] a;
            logic [31:0] wd;
            bit          err;
            int          kind;
            kind = int'($urandom_range(0, 19));
            rd   = (kind < 9) || (kind == 19);
            wr   = (kind >= 9);
            a    = 32'($urandom_range(0, DEPTH - 1)) << 2;
            if (kind == 17) a = a | 32'($urandom_range(1, 3));
            if (kind == 18) a = a + (32'($urandom_range(1, 4000)) << 10);
            wd  = $urandom;
            err = is_illegal(rd, wr, a);
            access(rd, wr, a, wd, 1'($urandom_range(0, 1)), err,
                   err ? 32'h0 : model_mem[a[9:2]], "rand");
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        idle(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave that sits at the far end of the mem_read/mem_write control lines driven by the decode stage.
- Services one word access at a time from an internal word array, with a fixed number of wait states.
- Holds the pipeline through stall until the access completes, and flags illegal requests on addr_err.
- Replaces the zero-latency ideal data memory, so the pipeline can be exercised against realistic memory timing.

Parameters:
- DATA_W, 32: data word width in bits.
- ADDR_W, 32: byte-address width in bits.
- DEPTH, 256: number of words in the array; power of two.
- LATENCY, 2: wait-state cycles per access; legal range 1..15; held in a 4-bit counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  read request from the datapath.
- mem_write  in  1  write request from the datapath.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  load data; registered; held until the next read completes.
- rvalid  out  1  one-cycle pulse when rdata carries newly completed load data.
- stall  out  1  pipeline hold request.
- addr_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, counter=0, rdata=0, rvalid=0, addr_err=0. stall is 0 in the cycle after reset.
- Array contents are not reset and are undefined at power-up.
- States: IDLE, BUSY, DONE.
- IDLE, request classification:
  - A request exists when mem_read|mem_write=1.
  - The request is illegal if any of these hold: both mem_read and mem_write are high; addr[1:0]!=0; the word index addr>>2 is >= DEPTH.
  - Illegal request: stay in IDLE, stall=0, addr_err=1 in the next cycle (registered pulse), no array access, rdata unchanged.
  - Legal request: capture addr, wdata and the read/write type; load counter with LATENCY-1; go to BUSY.
  - stall=1 combinationally in that same IDLE cycle, so the pipeline never advances past an unserved request.
- BUSY:
  - stall=1; counter decrements each cycle.
  - When counter==0, the access is performed on that clock edge and the state moves to DONE.
  - Write: array[word] <= captured wdata.
  - Read: rdata <= array[word].
- DONE:
  - stall=0; rvalid=1 if the access was a read.
  - Request inputs are ignored, because they still belong to the instruction just served.
  - Next state is unconditionally IDLE.
- Timing: for a legal request first presented in cycle T, stall is high in cycles T..T+LATENCY and DONE occurs in cycle T+LATENCY+1.
  - The earliest next request is accepted at T+LATENCY+2.
  - Back-to-back accesses therefore cost LATENCY+2 cycles each.
- Captured values: addr and wdata changes during BUSY have no effect; the captured values are used.
- Read-after-write: a read to the same word returns the last committed write value.
- Reset mid-operation: rst in BUSY gives IDLE next cycle with stall=0 and no write commit. The array keeps its prior contents.
- Width rules: word index = addr[log2(DEPTH)+1:2]. Bits of addr above that field participate only in the range check.

Test Plan:
- Write, then read (LATENCY=2):
  - Write 0xDEADBEEF to addr 0x10 at cycle T → stall=1 at T, T+1, T+2; stall=0 at T+3 (DONE); no rvalid.
  - Then read 0x10 → rvalid=1 in DONE with rdata=0xDEADBEEF.
- Misaligned read at addr 0x13 → addr_err=1 for exactly 1 cycle; stall stays 0; rdata unchanged.
- mem_read=mem_write=1 at addr 0x20 with wdata 0x1 → addr_err pulse; a later read of 0x20 returns its previous value.
- Out-of-range access at addr 0x400 (DEPTH=256) → addr_err pulse, no stall. Access at addr 0x3FC → legal, completes normally.
- Reset during BUSY:
  - Write 0x12345678 to 0x20, which previously held 0xAAAA5555.
  - Assert rst in cycle T+1 → stall=0 at T+2.
  - A subsequent read of 0x20 returns 0xAAAA5555.
- Input changes while stalled:
  - Read 0x10 with addr toggled to 0x14 during BUSY → returns the 0x10 data.
  - A request held through DONE is not re-serviced.
  - The next request is accepted at T+4, and rdata is held between reads.
